// File: rtl/snes_pad_scheduler.sv
// snes_pad_scheduler: poll scheduler for two SNES pads sharing one latch/clock bus.
// Shifts 16 bits from both pads at once, publishes 12 buttons + presence per pad.
// Optional feature macro: SNES_EDGE_EVENTS_EN adds per-pad press-event outputs.
module snes_pad_scheduler #(
    parameter int unsigned CLK_HALF      = 300,
    parameter int unsigned LATCH_CYCLES  = 600,
    parameter int unsigned POLL_INTERVAL = 30000
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        pad0_dout,
    input  logic        pad1_dout,
    input  logic        poll_req,
    output logic        pad_latch,
    output logic        pad_clk,
    output logic [11:0] pad0_buttons,
    output logic [11:0] pad1_buttons,
    output logic        pad0_present,
    output logic        pad1_present,
    output logic        updated,
    output logic        busy
`ifdef SNES_EDGE_EVENTS_EN
    ,
    output logic [11:0] pad0_pressed,
    output logic [11:0] pad1_pressed
`endif
);

    localparam int unsigned MaxA    = (LATCH_CYCLES > CLK_HALF) ? LATCH_CYCLES : CLK_HALF;
    localparam int unsigned MaxLoad = (POLL_INTERVAL > MaxA) ? POLL_INTERVAL : MaxA;
    localparam int unsigned CntW    = (MaxLoad > 1) ? $clog2(MaxLoad) : 1;

    localparam logic [CntW-1:0] LoadLatch = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0] LoadHalf  = CntW'(CLK_HALF - 1);
    localparam logic [CntW-1:0] LoadWait  = CntW'(POLL_INTERVAL - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLatch   = 3'd1;
    localparam logic [2:0] StGap     = 3'd2;
    localparam logic [2:0] StShiftLo = 3'd3;
    localparam logic [2:0] StShiftHi = 3'd4;
    localparam logic [2:0] StDone    = 3'd5;
    localparam logic [2:0] StWait    = 3'd6;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic            pend_q, pend_d;

    logic [15:0] raw0_q, raw1_q;
    logic [11:0] btn0_q, btn1_q;
    logic        present0_q, present1_q;

    logic        sample, publish;
    logic        new_present0, new_present1;
    logic [11:0] new_btn0, new_btn1;

    // Next-state, phase timer and pending-request logic
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cnt_q == '0) begin
                    state_d = StLatch;
                    cnt_d   = LoadLatch;
                end
            end
            StLatch: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = LoadHalf;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StShiftLo;
                    cnt_d   = LoadHalf;
                    bit_d   = 4'd0;
                end
            end
            StShiftLo: begin
                if (cnt_q == '0) begin
                    state_d = StShiftHi;
                    cnt_d   = LoadHalf;
                end
            end
            StShiftHi: begin
                if (cnt_q == '0) begin
                    if (bit_q == 4'd15) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShiftLo;
                        bit_d   = bit_q + 4'd1;
                    end
                    cnt_d = LoadHalf;
                end
            end
            StDone: begin
                // A request seen during the poll, or in this very cycle, restarts at once
                if (pend_q || poll_req) begin
                    state_d = StLatch;
                    cnt_d   = LoadLatch;
                end else begin
                    state_d = StWait;
                    cnt_d   = LoadWait;
                end
            end
            StWait: begin
                if (pend_q || cnt_q == '0) begin
                    state_d = StLatch;
                    cnt_d   = LoadLatch;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // The poll starting from WAIT/DONE serves every request seen so far
        pend_d = pend_q;
        if (state_d == StLatch && (state_q == StWait || state_q == StDone)) begin
            pend_d = 1'b0;
        end else if (poll_req) begin
            pend_d = 1'b1;
        end
    end

    // Sequencer state; IDLE counter starts at 1 so IDLE spans one full cycle after release
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= CntW'(1);
            bit_q   <= 4'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            pend_q  <= pend_d;
        end
    end

    assign sample  = (state_q == StShiftLo) && (cnt_q == LoadHalf);
    assign publish = (state_q == StShiftHi) && (cnt_q == '0) && (bit_q == 4'd15);

    // A disconnected pad reads all zeros through the board pull-down
    assign new_present0 = (raw0_q != 16'h0000);
    assign new_present1 = (raw1_q != 16'h0000);
    assign new_btn0     = new_present0 ? ~raw0_q[11:0] : 12'h000;
    assign new_btn1     = new_present1 ? ~raw1_q[11:0] : 12'h000;

    // Raw capture on the first SHIFT_LO cycle, then atomic publish on entry to DONE
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            raw0_q     <= 16'h0000;
            raw1_q     <= 16'h0000;
            btn0_q     <= 12'h000;
            btn1_q     <= 12'h000;
            present0_q <= 1'b0;
            present1_q <= 1'b0;
        end else begin
            if (sample) begin
                raw0_q[bit_q] <= pad0_dout;
                raw1_q[bit_q] <= pad1_dout;
            end
            if (publish) begin
                btn0_q     <= new_btn0;
                btn1_q     <= new_btn1;
                present0_q <= new_present0;
                present1_q <= new_present1;
            end
        end
    end

`ifdef SNES_EDGE_EVENTS_EN
    logic [11:0] pressed0_q, pressed1_q;

    // Press events live for the DONE cycle only; a newly attached pad reports none
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pressed0_q <= 12'h000;
            pressed1_q <= 12'h000;
        end else if (publish) begin
            pressed0_q <= present0_q ? (new_btn0 & ~btn0_q) : 12'h000;
            pressed1_q <= present1_q ? (new_btn1 & ~btn1_q) : 12'h000;
        end else begin
            pressed0_q <= 12'h000;
            pressed1_q <= 12'h000;
        end
    end

    assign pad0_pressed = pressed0_q;
    assign pad1_pressed = pressed1_q;
`endif

    assign pad_latch    = (state_q == StLatch);
    assign pad_clk      = (state_q != StShiftLo);
    assign updated      = (state_q == StDone);
    assign busy         = (state_q == StLatch) || (state_q == StGap) ||
                          (state_q == StShiftLo) || (state_q == StShiftHi) ||
                          (state_q == StDone);
    assign pad0_buttons = btn0_q;
    assign pad1_buttons = btn1_q;
    assign pad0_present = present0_q;
    assign pad1_present = present1_q;

endmodule

// File: tb/tb_snes_pad_scheduler.sv
// tb_snes_pad_scheduler: directed bench for snes_pad_scheduler with small timing parameters.
module tb_snes_pad_scheduler;

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        pad0_dout, pad1_dout;
    logic        poll_req;
    logic        pad_latch, pad_clk;
    logic [11:0] pad0_buttons, pad1_buttons;
    logic        pad0_present, pad1_present;
    logic        updated, busy;
`ifdef SNES_EDGE_EVENTS_EN
    logic [11:0] pad0_pressed, pad1_pressed;
`endif

    logic [15:0] pad0_raw, pad1_raw;
    logic [4:0]  pad_idx = 5'd0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n;

    snes_pad_scheduler #(
        .CLK_HALF     (2),
        .LATCH_CYCLES (4),
        .POLL_INTERVAL(20)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .pad0_dout   (pad0_dout),
        .pad1_dout   (pad1_dout),
        .poll_req    (poll_req),
        .pad_latch   (pad_latch),
        .pad_clk     (pad_clk),
        .pad0_buttons(pad0_buttons),
        .pad1_buttons(pad1_buttons),
        .pad0_present(pad0_present),
        .pad1_present(pad1_present),
        .updated     (updated),
        .busy        (busy)
`ifdef SNES_EDGE_EVENTS_EN
        ,
        .pad0_pressed(pad0_pressed),
        .pad1_pressed(pad1_pressed)
`endif
    );

    always #5 clk_50 = ~clk_50;

    // Pad model: latch reloads bit 0, each pad_clk rise presents the next bit
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_idx <= 5'd0;
        else           pad_idx <= pad_idx + 5'd1;
    end
    assign pad0_dout = (pad_idx < 5'd16) ? pad0_raw[pad_idx[3:0]] : 1'b0;
    assign pad1_dout = (pad_idx < 5'd16) ? pad1_raw[pad_idx[3:0]] : 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    task automatic wait_updated(input string tag, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 400) begin
            step();
            cnt++;
            seen = updated;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_latch(input string tag, output int cnt);
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < 400) begin
            step();
            cnt++;
            seen = pad_latch;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n  = 1'b0;
        poll_req = 1'b0;
        pad0_raw = 16'hFFFE;   // B pressed
        pad1_raw = 16'hF7FF;   // R pressed
        repeat (3) step();
        check("rst_ctrl", {pad_latch, pad_clk, updated, busy, pad0_present, pad1_present},
              6'b010000);
        check("rst_btn", {pad0_buttons, pad1_buttons}, 24'h0);

        // Release: latch rises two cycles later
        reset_n = 1'b1;
        step();
        check("rel_latch_c1", pad_latch, 0);
        step();
        check("rel_latch_c2", pad_latch, 1);
        check("busy_latch", busy, 1);

        // Test 1: basic poll timing and decode
        repeat (3) step();
        check("latch_hold", pad_latch, 1);
        step();
        check("latch_fall", pad_latch, 0);
        check("gap_clk", pad_clk, 1);
        repeat (2) step();
        check("shift_lo_clk", pad_clk, 0);
        wait_updated("upd_seen1", n);
        check("upd_latency1", n + 6, 70);
        check("p0_btn1", pad0_buttons, 12'h001);
        check("p1_btn1", pad1_buttons, 12'h800);
        check("present1", {pad0_present, pad1_present}, 2'b11);
        step();
        check("done_pulse", {updated, busy}, 2'b00);
        check("p0_btn_hold", pad0_buttons, 12'h001);
        wait_latch("latch_seen2", n);
        check("period", n + 1, 21);

        // Test 2: pad 1 disconnected
        pad0_raw = 16'hFAAA;
        pad1_raw = 16'h0000;
        wait_updated("upd_seen2", n);
        check("upd_latency2", n, 70);
        check("p0_btn2", pad0_buttons, 12'h555);
        check("p0_present2", pad0_present, 1);
        check("p1_absent", pad1_present, 0);
        check("p1_btn_absent", pad1_buttons, 12'h000);

        // Test 3: request in the 5th WAIT cycle
        repeat (5) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        check("req_latch_c1", pad_latch, 0);
        step();
        check("req_latch_c2", pad_latch, 1);

        // Test 4: three requests mid-poll merge into one back-to-back poll
        pad0_raw = 16'h8000;
        pad1_raw = 16'h0001;
        repeat (10) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        repeat (25) step();
        check("hi7_clk", pad_clk, 1);
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        repeat (13) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        wait_updated("upd_seen3", n);
        check("upd_latency3", n + 51, 70);
        check("p0_btn3", pad0_buttons, 12'hFFF);
        check("p1_btn3", pad1_buttons, 12'hFFE);
        check("present3", {pad0_present, pad1_present}, 2'b11);
        step();
        check("b2b_latch", {pad_latch, busy}, 2'b11);
        wait_updated("upd_seen4", n);
        check("upd_latency4", n, 70);
        step();
        check("no_third", {pad_latch, busy}, 2'b00);
        wait_latch("latch_seen5", n);
        check("period_after", n + 1, 21);

        // Request in the DONE cycle restarts immediately
        wait_updated("upd_seen5", n);
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        check("done_req", pad_latch, 1);

        // Test 5: reset in the middle of SHIFT_LO
        repeat (6) step();
        check("pre_rst_clk", pad_clk, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {pad_latch, pad_clk, updated, busy, pad0_present, pad1_present},
              6'b010000);
        check("mid_rst_btn", {pad0_buttons, pad1_buttons}, 24'h0);
        step();
        reset_n  = 1'b1;
        pad0_raw = 16'hFF7F;   // E pressed
        pad1_raw = 16'hFFFF;   // nothing pressed, connected
        step();
        check("rel2_latch_c1", pad_latch, 0);
        step();
        check("rel2_latch_c2", pad_latch, 1);
        wait_updated("upd_seen6", n);
        check("upd_latency6", n, 70);
        check("p0_btn6", pad0_buttons, 12'h080);
        check("p1_btn6", pad1_buttons, 12'h000);
        check("present6", {pad0_present, pad1_present}, 2'b11);
`ifdef SNES_EDGE_EVENTS_EN
        check("pressed_after_rst", {pad0_pressed, pad1_pressed}, 24'h0);

        // Test 6: A pressed, then held across a second poll
        pad0_raw = 16'hFEFF;
        pad1_raw = 16'h0000;
        wait_latch("latch_seen7", n);
        wait_updated("upd_seen7", n);
        check("p0_pressed_a", pad0_pressed, 12'h100);
        check("p1_pressed_gone", pad1_pressed, 12'h000);
        step();
        check("pressed_clear", pad0_pressed, 12'h000);
        pad1_raw = 16'hFFFE;
        wait_latch("latch_seen8", n);
        wait_updated("upd_seen8", n);
        check("p0_pressed_held", pad0_pressed, 12'h000);
        check("p1_btn_attach", pad1_buttons, 12'h001);
        check("p1_pressed_attach", pad1_pressed, 12'h000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
